// File: rtl/fwd_operand_reg_if.sv
// Operand-forwarding bus between the ID stage and the ID/EX operand registers.
// The master drives the sources and controls; the slave returns the registered operands.
interface fwd_operand_reg_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              en;
  logic              flush;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [WIDTH-1:0]  rs_data;
  logic [WIDTH-1:0]  rt_data;
  logic              exmem_wr;
  logic [ADDR_W-1:0] exmem_rd;
  logic [WIDTH-1:0]  exmem_data;
  logic              memwb_wr;
  logic [ADDR_W-1:0] memwb_rd;
  logic [WIDTH-1:0]  memwb_data;
  logic [WIDTH-1:0]  a_out;
  logic [WIDTH-1:0]  b_out;
  logic [1:0]        a_sel;
  logic [1:0]        b_sel;
  logic              valid_out;
  logic [CNT_W-1:0]  fwd_count;

  modport master (
    output en, flush, rs_addr, rt_addr, rs_data, rt_data,
           exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd, memwb_data,
    input  a_out, b_out, a_sel, b_sel, valid_out, fwd_count
  );

  modport slave (
    input  en, flush, rs_addr, rt_addr, rs_data, rt_data,
           exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd, memwb_data,
    output a_out, b_out, a_sel, b_sel, valid_out, fwd_count
  );
endinterface

// File: rtl/fwd_operand_reg.sv
// ID/EX operand registers with EX/MEM > MEM/WB > regfile forwarding, stall/flush,
// and a saturating count of forwarded operands.
module fwd_operand_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_operand_reg_if.slave bus
);

  localparam int unsigned SUM_W = CNT_W + 1;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_ZERO  = 2'b11;

  // Register 0 is hardwired zero and must never pick up a forwarded value.
  function automatic logic [1:0] resolve_sel(
    input logic [ADDR_W-1:0] addr,
    input logic              em_wr,
    input logic [ADDR_W-1:0] em_rd,
    input logic              mw_wr,
    input logic [ADDR_W-1:0] mw_rd
  );
    logic [1:0] sel;
    if (addr == '0)                     sel = SEL_ZERO;
    else if (em_wr && (em_rd == addr))  sel = SEL_EXMEM;
    else if (mw_wr && (mw_rd == addr))  sel = SEL_MEMWB;
    else                                sel = SEL_RF;
    return sel;
  endfunction

  function automatic logic [WIDTH-1:0] pick_val(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] rf,
    input logic [WIDTH-1:0] em,
    input logic [WIDTH-1:0] mw
  );
    logic [WIDTH-1:0] val;
    case (sel)
      SEL_EXMEM: val = em;
      SEL_MEMWB: val = mw;
      SEL_ZERO:  val = '0;
      default:   val = rf;
    endcase
    return val;
  endfunction

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       a_sel_c, b_sel_c;
  logic [WIDTH-1:0] a_val_c, b_val_c;
  logic [1:0]       fwd_inc_c;
  logic [SUM_W-1:0] cnt_sum_c;
  logic [CNT_W-1:0] cnt_sat_c;

  always_comb begin
    a_sel_d = a_sel_q;
    b_sel_d = b_sel_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;

    a_sel_c = resolve_sel(bus.rs_addr, bus.exmem_wr, bus.exmem_rd, bus.memwb_wr, bus.memwb_rd);
    b_sel_c = resolve_sel(bus.rt_addr, bus.exmem_wr, bus.exmem_rd, bus.memwb_wr, bus.memwb_rd);
    a_val_c = pick_val(a_sel_c, bus.rs_data, bus.exmem_data, bus.memwb_data);
    b_val_c = pick_val(b_sel_c, bus.rt_data, bus.exmem_data, bus.memwb_data);

    // Selects 01 and 10 are exactly the forwarded cases (one bit set).
    fwd_inc_c = 2'(a_sel_c[0] ^ a_sel_c[1]) + 2'(b_sel_c[0] ^ b_sel_c[1]);
    cnt_sum_c = {1'b0, cnt_q} + SUM_W'(fwd_inc_c);
    cnt_sat_c = cnt_sum_c[CNT_W] ? {CNT_W{1'b1}} : cnt_sum_c[CNT_W-1:0];

    if (bus.flush) begin
      a_d     = '0;
      b_d     = '0;
      a_sel_d = SEL_RF;
      b_sel_d = SEL_RF;
      valid_d = 1'b0;
    end else if (bus.en) begin
      a_d     = a_val_c;
      b_d     = b_val_c;
      a_sel_d = a_sel_c;
      b_sel_d = b_sel_c;
      valid_d = 1'b1;
      cnt_d   = cnt_sat_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      a_sel_q <= SEL_RF;
      b_sel_q <= SEL_RF;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.a_sel     = a_sel_q;
  assign bus.b_sel     = b_sel_q;
  assign bus.valid_out = valid_q;
  assign bus.fwd_count = cnt_q;

endmodule

// File: tb/tb_fwd_operand_reg.sv
// Directed bench for fwd_operand_reg: vector table plus stall/flush/reset/saturation sequences.
module tb_fwd_operand_reg;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fwd_operand_reg_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(16)) ifb ();
  fwd_operand_reg_if #(.WIDTH(32), .ADDR_W(5), .CNT_W(4))  ifs ();

  fwd_operand_reg #(.WIDTH(32), .ADDR_W(5), .CNT_W(16)) dut_big (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  fwd_operand_reg #(.WIDTH(32), .ADDR_W(5), .CNT_W(4)) dut_small (
    .clk (clk),
    .rst (rst),
    .bus (ifs.slave)
  );

  typedef struct {
    logic        en;
    logic        flush;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        em_wr;
    logic [4:0]  em_rd;
    logic [31:0] em_data;
    logic        mw_wr;
    logic [4:0]  mw_rd;
    logic [31:0] mw_data;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [1:0]  exp_asel;
    logic [1:0]  exp_bsel;
    logic        exp_valid;
    logic [15:0] exp_cnt;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    ifb.en = v.en;        ifs.en = v.en;
    ifb.flush = v.flush;  ifs.flush = v.flush;
    ifb.rs_addr = v.rs_addr;  ifs.rs_addr = v.rs_addr;
    ifb.rt_addr = v.rt_addr;  ifs.rt_addr = v.rt_addr;
    ifb.rs_data = v.rs_data;  ifs.rs_data = v.rs_data;
    ifb.rt_data = v.rt_data;  ifs.rt_data = v.rt_data;
    ifb.exmem_wr = v.em_wr;     ifs.exmem_wr = v.em_wr;
    ifb.exmem_rd = v.em_rd;     ifs.exmem_rd = v.em_rd;
    ifb.exmem_data = v.em_data; ifs.exmem_data = v.em_data;
    ifb.memwb_wr = v.mw_wr;     ifs.memwb_wr = v.mw_wr;
    ifb.memwb_rd = v.mw_rd;     ifs.memwb_rd = v.mw_rd;
    ifb.memwb_data = v.mw_data; ifs.memwb_data = v.mw_data;
  endtask

  task automatic check_big(input string tag, input vec_t v);
    n_vec++;
    chk({tag, ".a_out"},     ifb.a_out,             v.exp_a);
    chk({tag, ".b_out"},     ifb.b_out,             v.exp_b);
    chk({tag, ".a_sel"},     32'(ifb.a_sel),        32'(v.exp_asel));
    chk({tag, ".b_sel"},     32'(ifb.b_sel),        32'(v.exp_bsel));
    chk({tag, ".valid_out"}, 32'(ifb.valid_out),    32'(v.exp_valid));
    chk({tag, ".fwd_count"}, 32'(ifb.fwd_count),    32'(v.exp_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  vec_t v;
  vec_t hold;
  int   exp_small;

  initial begin
    //          en flush rs rt rs_data  rt_data   emwr emrd em_data  mwwr mwrd mw_data   exp_a     exp_b     as     bs     vld cnt
    tbl[0] = '{1'b1, 1'b0, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,
               32'h11,   32'h22,   2'b00, 2'b00, 1'b1, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 5'd5, 5'd5, 32'h1,  32'h2,  1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
               32'hAAAA, 32'hAAAA, 2'b01, 2'b01, 1'b1, 16'd2};
    tbl[2] = '{1'b1, 1'b0, 5'd5, 5'd5, 32'h1,  32'h2,  1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB,
               32'hBBBB, 32'hBBBB, 2'b10, 2'b10, 1'b1, 16'd4};
    tbl[3] = '{1'b1, 1'b0, 5'd0, 5'd7, 32'h99, 32'h55, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd7, 32'h77,
               32'h0,    32'h77,   2'b11, 2'b10, 1'b1, 16'd5};
    tbl[4] = '{1'b1, 1'b0, 5'd8, 5'd9, 32'h1,  32'h2,  1'b1, 5'd9, 32'h1234, 1'b1, 5'd8, 32'h5678,
               32'h5678, 32'h1234, 2'b10, 2'b01, 1'b1, 16'd7};
    tbl[5] = '{1'b1, 1'b0, 5'd8, 5'd9, 32'hA0, 32'hB0, 1'b0, 5'd8, 32'h1234, 1'b0, 5'd9, 32'h5678,
               32'hA0,   32'hB0,   2'b00, 2'b00, 1'b1, 16'd7};
    tbl[6] = '{1'b1, 1'b1, 5'd1, 5'd2, 32'h3,  32'h4,  1'b1, 5'd1, 32'hCAFE, 1'b0, 5'd0, 32'h0,
               32'h0,    32'h0,    2'b00, 2'b00, 1'b0, 16'd7};
    tbl[7] = '{1'b0, 1'b1, 5'd1, 5'd2, 32'h3,  32'h4,  1'b1, 5'd2, 32'hCAFE, 1'b0, 5'd0, 32'h0,
               32'h0,    32'h0,    2'b00, 2'b00, 1'b0, 16'd7};
    tbl[8] = '{1'b1, 1'b0, 5'd0, 5'd0, 32'h3,  32'h4,  1'b1, 5'd0, 32'hF00D, 1'b1, 5'd0, 32'hBEEF,
               32'h0,    32'h0,    2'b11, 2'b11, 1'b1, 16'd7};
    tbl[9] = '{1'b0, 1'b0, 5'd3, 5'd4, 32'h33, 32'h44, 1'b1, 5'd3, 32'h9999, 1'b1, 5'd4, 32'h8888,
               32'h0,    32'h0,    2'b11, 2'b11, 1'b1, 16'd7};

    // Reset
    v = tbl[0];
    v.en = 1'b0;
    drive(v);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    v.exp_a = '0; v.exp_b = '0; v.exp_asel = 2'b00; v.exp_bsel = 2'b00;
    v.exp_valid = 1'b0; v.exp_cnt = '0;
    check_big("reset", v);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i]);
      step();
      check_big($sformatf("vec%0d", i), tbl[i]);
    end

    // Load one forwarded operand, then stall with scrambled inputs
    v = tbl[0];
    v.rs_addr = 5'd3; v.rt_addr = 5'd4; v.rs_data = 32'h33; v.rt_data = 32'h44;
    v.em_wr = 1'b1; v.em_rd = 5'd3; v.em_data = 32'hC0DE; v.mw_wr = 1'b0;
    v.exp_a = 32'hC0DE; v.exp_b = 32'h44; v.exp_asel = 2'b01; v.exp_bsel = 2'b00;
    v.exp_valid = 1'b1; v.exp_cnt = 16'd8;
    drive(v);
    step();
    check_big("load", v);
    hold = v;
    for (int i = 0; i < 3; i++) begin
      v.en = 1'b0; v.flush = 1'b0;
      v.rs_addr = 5'($urandom); v.rt_addr = 5'($urandom);
      v.rs_data = $urandom; v.rt_data = $urandom;
      v.em_wr = 1'b1; v.em_rd = v.rs_addr; v.em_data = $urandom;
      v.mw_wr = 1'b1; v.mw_rd = v.rt_addr; v.mw_data = $urandom;
      drive(v);
      step();
      check_big($sformatf("stall%0d", i), hold);
    end

    // Flush wins over en and adds no count
    v = hold;
    v.en = 1'b1; v.flush = 1'b1;
    v.exp_a = '0; v.exp_b = '0; v.exp_asel = 2'b00; v.exp_bsel = 2'b00;
    v.exp_valid = 1'b0; v.exp_cnt = 16'd8;
    drive(v);
    step();
    check_big("flush_en", v);

    // Reload two forwards, then reset arrives during a stall
    v = tbl[1];
    v.exp_cnt = 16'd10;
    drive(v);
    step();
    check_big("reload", v);
    v.en = 1'b0;
    drive(v);
    rst = 1'b1;
    step();
    rst = 1'b0;
    v.exp_a = '0; v.exp_b = '0; v.exp_asel = 2'b00; v.exp_bsel = 2'b00;
    v.exp_valid = 1'b0; v.exp_cnt = '0;
    check_big("rst_stall", v);

    // Saturation on the 4-bit counter, both operands forwarded every cycle
    v = tbl[1];
    exp_small = 0;
    for (int k = 1; k <= 10; k++) begin
      drive(v);
      step();
      exp_small = (exp_small + 2 > 15) ? 15 : exp_small + 2;
      n_vec++;
      chk($sformatf("sat%0d.small_cnt", k), 32'(ifs.fwd_count), 32'(exp_small));
      chk($sformatf("sat%0d.big_cnt", k),   32'(ifb.fwd_count), 32'(2 * k));
      chk($sformatf("sat%0d.small_a", k),   ifs.a_out, 32'hAAAA);
    end

    // Reset with en still high clears the small instance
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    chk("rst_small.cnt",   32'(ifs.fwd_count), 32'd0);
    chk("rst_small.a",     ifs.a_out,          32'd0);
    chk("rst_small.b",     ifs.b_out,          32'd0);
    chk("rst_small.asel",  32'(ifs.a_sel),     32'd0);
    chk("rst_small.bsel",  32'(ifs.b_sel),     32'd0);
    chk("rst_small.valid", 32'(ifs.valid_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
